main_fsm: RTL

MAIN_FSM -- requirements
Module: main_fsm

---
 rtl/main_fsm.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/main_fsm.sv
// Multicycle processor main controller: Moore FSM sequencing fetch, decode and
// per-class execute steps, with control outputs decoded from the registered state.
module main_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic               NextPC,
    output logic               RegW,
    output logic               MemW,
    output logic               Branch,
    output logic               ALUOp,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_e;

    typedef struct packed {
        logic       ir_write;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       alu_op;
    } ctrl_t;

    state_e state_q, state_d;
    ctrl_t  ctrl;

    // Only the I and L bits of Funct steer sequencing.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = UNKNOWN;
                endcase
            end
            MEMADR:   state_d = Funct[0] ? MEMRD : MEMWR;
            MEMRD:    state_d = MEMWB;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    // NOTE: non-blocking assignment keeps every flop sampling pre-edge values,
    // so the simulated behaviour matches the synthesized registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the all-zero default ahead of the case gives every path a value,
    // so no latch is inferred and illegal encodings drive everything low.
    always_comb begin
        ctrl = '0;
        case (state_q)
            FETCH: begin
                ctrl.ir_write   = 1'b1;
                ctrl.next_pc    = 1'b1;
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = 2'b10;
                ctrl.result_src = 2'b10;
            end
            DECODE: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = 2'b10;
                ctrl.result_src = 2'b10;
            end
            MEMADR: begin
                ctrl.alu_src_b  = 2'b01;
            end
            MEMRD: begin
                ctrl.adr_src    = 1'b1;
            end
            MEMWB: begin
                ctrl.result_src = 2'b01;
                ctrl.reg_w      = 1'b1;
            end
            MEMWR: begin
                ctrl.adr_src    = 1'b1;
                ctrl.mem_w      = 1'b1;
            end
            EXECUTER: begin
                ctrl.alu_op     = 1'b1;
            end
            EXECUTEI: begin
                ctrl.alu_src_b  = 2'b01;
                ctrl.alu_op     = 1'b1;
            end
            ALUWB: begin
                ctrl.reg_w      = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_b  = 2'b01;
                ctrl.result_src = 2'b10;
                ctrl.branch     = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign IRWrite   = ctrl.ir_write;
    assign AdrSrc    = ctrl.adr_src;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ResultSrc = ctrl.result_src;
    assign NextPC    = ctrl.next_pc;
    assign RegW      = ctrl.reg_w;
    assign MemW      = ctrl.mem_w;
    assign Branch    = ctrl.branch;
    assign ALUOp     = ctrl.alu_op;
    assign State     = STATE_W'(state_q);

endmodule
